// File: rtl/vga_pattern_engine.sv
// vga_pattern_engine: VGA sync timing, frame-synchronous test patterns and a 2-stage pixel pipeline
module vga_pattern_engine #(
  parameter int RED_W       = 3,
  parameter int GRN_W       = 3,
  parameter int BLU_W       = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIX_DIV     = 4,
  parameter int CHECK_SHIFT = 5,
  parameter int BAR_W       = 32,
  parameter int AUTO_FRAMES = 120
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       sw,
  input  logic             auto_en,
  output logic [RED_W-1:0] red,
  output logic [GRN_W-1:0] green,
  output logic [BLU_W-1:0] blue,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic [3:0]       cur_pattern
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW = $clog2(H_TOT);
  localparam int RW = $clog2(V_TOT);
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam int FW = AUTO_FRAMES > 1 ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_END  = DW'(PIX_DIV - 1);
  localparam logic [FW-1:0] FRM_END  = FW'(AUTO_FRAMES - 1);
  localparam logic [CW-1:0] H_END    = CW'(H_TOT - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_EDGE   = CW'(H_ACTIVE - 2);
  localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE - BAR_W);
  localparam logic [CW-1:0] BAR_LEN  = CW'(BAR_W);
  localparam logic [CW-1:0] SEG_W    = CW'(H_ACTIVE / 8);
  localparam logic [RW-1:0] V_END    = RW'(V_TOT - 1);
  localparam logic [RW-1:0] V_ACT    = RW'(V_ACTIVE);
  localparam logic [RW-1:0] VS_BEG   = RW'(V_ACTIVE + V_FP);
  localparam logic [RW-1:0] VS_END   = RW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [RW-1:0] V_EDGE   = RW'(V_ACTIVE - 2);
  // {r,g,b} per bar, left to right: white yellow cyan green magenta red blue black
  localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] col_q, col_d, s1_col_q, s1_col_d, bar_pos_q, bar_pos_d;
  logic [RW-1:0] row_q, row_d, s1_row_q, s1_row_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]    cur_pattern_q, cur_pattern_d;
  logic [2:0]    rgb_q, rgb_d, pat_rgb;
  logic          s1_act_q, s1_act_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          pix_tick, boundary, chk, border, in_bar;

  always_comb begin
    pix_tick      = div_q == DIV_END;
    boundary      = pix_tick && col_q == '0 && row_q == '0;
    div_d         = pix_tick ? '0 : div_q + 1'b1;
    col_d         = !pix_tick ? col_q : col_q == H_END ? '0 : col_q + 1'b1;
    row_d         = !pix_tick || col_q != H_END ? row_q : row_q == V_END ? '0 : row_q + 1'b1;
    frame_cnt_d   = !auto_en ? '0 : !boundary ? frame_cnt_q : frame_cnt_q == FRM_END ? '0 : frame_cnt_q + 1'b1;
    cur_pattern_d = !boundary ? cur_pattern_q : !auto_en ? sw :
                    frame_cnt_q == FRM_END ? {1'b0, cur_pattern_q[2:0] + 3'd1} : cur_pattern_q;
    bar_pos_d     = !boundary ? bar_pos_q : bar_pos_q >= BAR_LAST ? '0 : bar_pos_q + 1'b1;
    s1_col_d      = pix_tick ? col_q : s1_col_q;
    s1_row_d      = pix_tick ? row_q : s1_row_q;
    s1_act_d      = pix_tick ? col_q < H_ACT && row_q < V_ACT : s1_act_q;
    s1_hs_d       = pix_tick ? !(col_q >= HS_BEG && col_q < HS_END) : s1_hs_q;
    s1_vs_d       = pix_tick ? !(row_q >= VS_BEG && row_q < VS_END) : s1_vs_q;
    chk           = s1_col_q[CHECK_SHIFT] ^ s1_row_q[CHECK_SHIFT];
    border        = s1_row_q < RW'(2) || s1_row_q >= V_EDGE || s1_col_q < CW'(2) || s1_col_q >= H_EDGE;
    in_bar        = s1_col_q >= bar_pos_q && s1_col_q < bar_pos_q + BAR_LEN;
    pat_rgb       = cur_pattern_q == 4'd1 ? 3'b100 :
                    cur_pattern_q == 4'd2 ? 3'b010 :
                    cur_pattern_q == 4'd3 ? 3'b001 :
                    cur_pattern_q == 4'd4 ? {3{chk}} :
                    cur_pattern_q == 4'd5 ? BAR_RGB[3'(s1_col_q / SEG_W)] :
                    cur_pattern_q == 4'd6 ? {3{border}} :
                    cur_pattern_q == 4'd7 ? (in_bar ? 3'b111 : 3'b001) : 3'b000;
    rgb_d         = !pix_tick ? rgb_q : s1_act_q ? pat_rgb : 3'b000;
    hsync_d       = pix_tick ? s1_hs_q : hsync_q;
    vsync_d       = pix_tick ? s1_vs_q : vsync_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      frame_cnt_q   <= '0;
      cur_pattern_q <= '0;
      bar_pos_q     <= '0;
      s1_col_q      <= '0;
      s1_row_q      <= '0;
      s1_act_q      <= 1'b0;
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
    end else begin
      div_q         <= div_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_cnt_q   <= frame_cnt_d;
      cur_pattern_q <= cur_pattern_d;
      bar_pos_q     <= bar_pos_d;
      s1_col_q      <= s1_col_d;
      s1_row_q      <= s1_row_d;
      s1_act_q      <= s1_act_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign red         = {RED_W{rgb_q[2]}};
  assign green       = {GRN_W{rgb_q[1]}};
  assign blue        = {BLU_W{rgb_q[0]}};
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = boundary && !reset;
  assign cur_pattern = cur_pattern_q;
endmodule

// File: tb/tb_vga_pattern_engine.sv
// tb_vga_pattern_engine: scoreboard bench comparing every displayed pixel against a frame-level reference model
module tb_vga_pattern_engine;
  localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACTIVE = 24, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int PD = 2, CS = 3, BAR_W = 56, AF = 2;
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FT = H_TOT * V_TOT;
  localparam int FCLK = FT * PD;

  logic       clk = 1'b0, reset = 1'b1, auto_en = 1'b0;
  logic [3:0] sw = 4'd0;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       hsync, vsync, frame_start;
  logic [3:0] cur_pattern;

  vga_pattern_engine #(
    .RED_W(3), .GRN_W(3), .BLU_W(2),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PD), .CHECK_SHIFT(CS), .BAR_W(BAR_W), .AUTO_FRAMES(AF)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .auto_en(auto_en),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .cur_pattern(cur_pattern)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] v;
    int         col;
    int         row;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0, miscompares = 0;
  int   c = 0, pat = 0, bar = 0, fcnt = 0;
  int   m_p, m_col, m_row;
  bit   ev = 1'b0;
  exp_t m_e, k_e;

  function automatic logic [9:0] pins(logic [2:0] rgb, logic hs, logic vs);
    return {{3{rgb[2]}}, {3{rgb[1]}}, {2{rgb[0]}}, hs, vs};
  endfunction

  function automatic logic sync_lvl(int x, int beg, int len);
    return !(x >= beg && x < beg + len);
  endfunction

  function automatic logic [2:0] pix_rgb(int col, int row, int p, int b);
    if (col >= H_ACTIVE || row >= V_ACTIVE) return 3'b000;
    case (p)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      4: return (((col >> CS) + (row >> CS)) % 2 == 1) ? 3'b111 : 3'b000;
      5: case (col / (H_ACTIVE / 8))
           0: return 3'b111;
           1: return 3'b110;
           2: return 3'b011;
           3: return 3'b010;
           4: return 3'b101;
           5: return 3'b100;
           6: return 3'b001;
           default: return 3'b000;
         endcase
      6: return (row < 2 || row > V_ACTIVE - 3 || col < 2 || col > H_ACTIVE - 3) ? 3'b111 : 3'b000;
      7: return (col >= b && col < b + BAR_W) ? 3'b111 : 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Reference model: c counts clocks since reset release; pixel n is shown on tick n.
  initial forever begin
    @(posedge clk);
    ev = 1'b0;
    if (reset) begin
      c = 0; pat = 0; bar = 0; fcnt = 0;
      sbq.delete();
      m_e.v = pins(3'b000, 1'b1, 1'b1);
      m_e.col = -1;
      m_e.row = -1;
      sbq.push_back(m_e);
      sbq.push_back(m_e);
      ev = 1'b1;
    end else begin
      if (!auto_en) fcnt = 0;
      if (c % PD == PD - 1) begin
        m_p = (c / PD) % FT;
        m_col = m_p % H_TOT;
        m_row = m_p / H_TOT;
        if (m_p == 0) begin
          if (!auto_en) pat = int'(sw);
          else if (fcnt == AF - 1) begin fcnt = 0; pat = (pat + 1) % 8; end
          else fcnt++;
          bar = (bar == H_ACTIVE - BAR_W) ? 0 : bar + 1;
        end
        m_e.v = pins(pix_rgb(m_col, m_row, pat, bar),
                     sync_lvl(m_col, H_ACTIVE + H_FP, H_SYNC), sync_lvl(m_row, V_ACTIVE + V_FP, V_SYNC));
        m_e.col = m_col;
        m_e.row = m_row;
        sbq.push_back(m_e);
        ev = 1'b1;
      end
      c++;
    end
  end

  // Monitor: whenever the DUT updates its pins, pop and compare.
  initial forever begin
    @(posedge clk);
    #1;
    if (ev) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard: queue empty, pins=%b", {red, green, blue, hsync, vsync});
      end else begin
        k_e = sbq.pop_front();
        if ({red, green, blue, hsync, vsync} !== k_e.v) begin
          miscompares++;
          $display("FAIL pixel col=%0d row=%0d: got rgbhv=%b want %b", k_e.col, k_e.row,
                   {red, green, blue, hsync, vsync}, k_e.v);
        end
      end
      vectors++;
      if (cur_pattern !== 4'(pat)) begin
        miscompares++;
        $display("FAIL cur_pattern: got %0d want %0d", cur_pattern, pat);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    vectors++;
    if (frame_start !== (!reset && c % PD == PD - 1 && (c / PD) % FT == 0)) begin
      miscompares++;
      $display("FAIL frame_start: got %b at clk %0d after reset", frame_start, c);
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int pats[8] = '{2, 3, 4, 5, 6, 0, 7, 7};
    int r;
    sw = 4'd1;
    reset = 1'b1;
    step(4);
    reset = 1'b0;
    step(FCLK + FCLK / 2 + 7 * PD + 1);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(FCLK - 2 * H_TOT * PD, 2 * H_TOT * PD));
      step(r);
      sw = (i == 5) ? 4'($urandom_range(15, 8)) : 4'(pats[i]);
      step(FCLK - r);
    end
    step(FCLK);
    sw = 4'd6;
    step(FCLK / 2);
    auto_en = 1'b1;
    sw = 4'($urandom_range(15, 0));
    step(4 * FCLK);
    auto_en = 1'b0;
    sw = 4'd3;
    step(FCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
